// File: rtl/rfsoc_reg_pkg.sv
// rtl/rfsoc_reg_pkg.sv - address map, field codes and helpers for the RFSoC register array
package rfsoc_reg_pkg;

    localparam logic [15:0] CH_STRIDE = 16'h0010;
    localparam logic [15:0] DAC_BASE  = 16'h0000;
    localparam logic [15:0] ADC_BASE  = 16'h0400;
    localparam logic [15:0] GLB_BASE  = 16'h0800;

    localparam logic [1:0] FLD_ADDR = 2'd0;
    localparam logic [1:0] FLD_SIZE = 2'd1;
    localparam logic [1:0] FLD_CTRL = 2'd2;
    localparam logic [1:0] FLD_STAT = 2'd3;

    localparam logic [1:0] GLB_IRQ_EN   = 2'd0;
    localparam logic [1:0] GLB_IRQ_STAT = 2'd1;
    localparam logic [1:0] GLB_RSVD     = 2'd2;
    localparam logic [1:0] GLB_VERSION  = 2'd3;

    localparam int IRQ_DAC_DONE = 0;
    localparam int IRQ_ADC_DONE = 8;
    localparam int IRQ_DAC_ERR  = 16;
    localparam int IRQ_ADC_ERR  = 24;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0000;

    typedef enum logic [1:0] {
        REG_DAC,
        REG_ADC,
        REG_GLB,
        REG_NONE
    } region_e;

    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] cap_size;
        logic        ctrl_reset;
        logic        busy;
        logic        overrun;
    } chan_regs_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        return (old_v & ~strb_mask(strb)) | (new_v & strb_mask(strb));
    endfunction

endpackage

// File: rtl/rfsoc_reg_chan.sv
// rtl/rfsoc_reg_chan.sv - one DAC/ADC channel block: addr/size/ctrl/status, start pulse, read mux
module rfsoc_reg_chan
    import rfsoc_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_sel,
    input  logic [1:0]  field,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        done,
    input  logic        err,
    output logic [31:0] start_addr,
    output logic [31:0] cap_size,
    output logic        start,
    output logic        chan_reset,
    output logic [31:0] rd_word
);

    chan_regs_t r;

    logic ctrl_wr;
    logic start_req;
    logic start_ok;
    logic ovr_clr;

    assign ctrl_wr   = wr_sel && (field == FLD_CTRL) && wstrb[0];
    assign start_req = ctrl_wr && wdata[0];
    // The reset level gating a start is the value held before this write.
    assign start_ok  = start_req && !r.busy && !r.ctrl_reset;
    assign ovr_clr   = wr_sel && (field == FLD_STAT) && wstrb[0] && wdata[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r     <= '0;
            start <= 1'b0;
        end else begin
            if (wr_sel && (field == FLD_ADDR))
                r.start_addr <= strb_merge(r.start_addr, wdata, wstrb);
            if (wr_sel && (field == FLD_SIZE))
                r.cap_size <= strb_merge(r.cap_size, wdata, wstrb);
            if (ctrl_wr)
                r.ctrl_reset <= wdata[1];

            start <= start_ok;

            // An accepted start outranks a same-cycle completion.
            if (start_ok)
                r.busy <= 1'b1;
            else if (done || err || r.ctrl_reset)
                r.busy <= 1'b0;

            if (start_req && !start_ok)
                r.overrun <= 1'b1;
            else if (ovr_clr)
                r.overrun <= 1'b0;
        end
    end

    assign start_addr = r.start_addr;
    assign cap_size   = r.cap_size;
    assign chan_reset = r.ctrl_reset;

    always_comb begin
        rd_word = '0;
        case (field)
            FLD_ADDR: rd_word = r.start_addr;
            FLD_SIZE: rd_word = r.cap_size;
            FLD_CTRL: rd_word = {30'd0, r.ctrl_reset, 1'b0};
            FLD_STAT: rd_word = {30'd0, r.overrun, r.busy};
            default:  rd_word = '0;
        endcase
    end

endmodule

// File: rtl/rfsoc_reg_array.sv
// rtl/rfsoc_reg_array.sv - multi-channel RFSoC control/status register file with IRQ and registered read
module rfsoc_reg_array
    import rfsoc_reg_pkg::*;
#(
    parameter int          NUM_DAC = 2,
    parameter int          NUM_ADC = 2,
    parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wren,
    input  logic [15:0]          offset,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    input  logic                 rd_en,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    output logic [NUM_DAC*32-1:0] dac_start_addr,
    output logic [NUM_DAC*32-1:0] dac_cap_size,
    output logic [NUM_DAC-1:0]   dac_start,
    output logic [NUM_DAC-1:0]   dac_reset,
    input  logic [NUM_DAC-1:0]   dac_done,
    input  logic [NUM_DAC-1:0]   dac_err,
    output logic [NUM_ADC*32-1:0] adc_start_addr,
    output logic [NUM_ADC*32-1:0] adc_cap_size,
    output logic [NUM_ADC-1:0]   adc_start,
    output logic [NUM_ADC-1:0]   adc_reset,
    input  logic [NUM_ADC-1:0]   adc_done,
    input  logic [NUM_ADC-1:0]   adc_err,
    output logic                 irq
);

    region_e     region;
    logic [5:0]  ch_idx;
    logic [1:0]  field;
    logic [31:0] dac_rd [NUM_DAC];
    logic [31:0] adc_rd [NUM_ADC];
    logic [31:0] rd_mux;
    logic [31:0] irq_en;
    logic [31:0] irq_stat;
    logic [31:0] irq_set;
    logic [31:0] irq_clr;
    logic        irq_en_wr;

    assign ch_idx = offset[9:4];
    assign field  = offset[3:2];

    // Misaligned byte addresses are treated as unmapped.
    always_comb begin
        region = REG_NONE;
        if (offset[1:0] == 2'b00) begin
            if (offset[15:10] == DAC_BASE[15:10])
                region = REG_DAC;
            else if (offset[15:10] == ADC_BASE[15:10])
                region = REG_ADC;
            else if (offset[15:4] == GLB_BASE[15:4])
                region = REG_GLB;
        end
    end

    for (genvar i = 0; i < NUM_DAC; i++) begin : g_dac
        rfsoc_reg_chan u_chan (
            .clk        (clk),
            .rst        (rst),
            .wr_sel     (wren && (region == REG_DAC) && (ch_idx == 6'(i))),
            .field      (field),
            .wdata      (wdata),
            .wstrb      (wstrb),
            .done       (dac_done[i]),
            .err        (dac_err[i]),
            .start_addr (dac_start_addr[i*32 +: 32]),
            .cap_size   (dac_cap_size[i*32 +: 32]),
            .start      (dac_start[i]),
            .chan_reset (dac_reset[i]),
            .rd_word    (dac_rd[i])
        );
    end

    for (genvar i = 0; i < NUM_ADC; i++) begin : g_adc
        rfsoc_reg_chan u_chan (
            .clk        (clk),
            .rst        (rst),
            .wr_sel     (wren && (region == REG_ADC) && (ch_idx == 6'(i))),
            .field      (field),
            .wdata      (wdata),
            .wstrb      (wstrb),
            .done       (adc_done[i]),
            .err        (adc_err[i]),
            .start_addr (adc_start_addr[i*32 +: 32]),
            .cap_size   (adc_cap_size[i*32 +: 32]),
            .start      (adc_start[i]),
            .chan_reset (adc_reset[i]),
            .rd_word    (adc_rd[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (region)
            REG_DAC: begin
                for (int i = 0; i < NUM_DAC; i++)
                    if (ch_idx == 6'(i)) rd_mux = dac_rd[i];
            end
            REG_ADC: begin
                for (int i = 0; i < NUM_ADC; i++)
                    if (ch_idx == 6'(i)) rd_mux = adc_rd[i];
            end
            REG_GLB: begin
                case (field)
                    GLB_IRQ_EN:   rd_mux = irq_en;
                    GLB_IRQ_STAT: rd_mux = irq_stat;
                    GLB_RSVD:     rd_mux = '0;
                    GLB_VERSION:  rd_mux = VERSION;
                    default:      rd_mux = '0;
                endcase
            end
            default: rd_mux = '0;
        endcase
    end

    // Only implemented channels can raise events, so unused status bits stay 0.
    always_comb begin
        irq_set = '0;
        for (int k = 0; k < NUM_DAC; k++) begin
            irq_set[IRQ_DAC_DONE + k] = dac_done[k];
            irq_set[IRQ_DAC_ERR + k]  = dac_err[k];
        end
        for (int k = 0; k < NUM_ADC; k++) begin
            irq_set[IRQ_ADC_DONE + k] = adc_done[k];
            irq_set[IRQ_ADC_ERR + k]  = adc_err[k];
        end
    end

    assign irq_en_wr = wren && (region == REG_GLB) && (field == GLB_IRQ_EN);
    assign irq_clr   = (wren && (region == REG_GLB) && (field == GLB_IRQ_STAT))
                     ? (wdata & strb_mask(wstrb)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en   <= '0;
            irq_stat <= '0;
            irq      <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
        end else begin
            if (irq_en_wr)
                irq_en <= strb_merge(irq_en, wdata, wstrb);
            // Set is OR'd after the clear so a same-cycle event survives W1C.
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
            irq      <= |(irq_stat & irq_en);
            rvalid   <= rd_en;
            if (rd_en)
                rdata <= rd_mux;
        end
    end

endmodule
